// File: rtl/uart_rx.sv
// UART receiver: 7 data bits LSB first, even parity, one stop bit.
// The serial input is synchronised, the frame is timed from the falling
// edge of the start bit, and every bit is sampled near its centre.
module uart_rx #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLK_PER_BIT / 2;
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity of a character: the parity bit that makes the total even.
  function automatic logic even_parity(input logic [6:0] v);
    return ^v;
  endfunction

  logic        rs_meta_r, rs_r, rs_prev_r;
  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [6:0]  char_r, char_s;
  logic        par_r, par_s;
  logic [6:0]  data_r, data_s;
  logic        valid_r, valid_s;
  logic        perr_r, perr_s;
  logic        ferr_r, ferr_s;
  logic        busy_r, busy_s;

  // Two-flop synchroniser for rx plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_r <= 1'b1;
      rs_r      <= 1'b1;
      rs_prev_r <= 1'b1;
    end else begin
      rs_meta_r <= rx;
      rs_r      <= rs_meta_r;
      rs_prev_r <= rs_r;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      char_r  <= 7'd0;
      par_r   <= 1'b0;
      data_r  <= 7'd0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      char_r  <= char_s;
      par_r   <= par_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      perr_r  <= perr_s;
      ferr_r  <= ferr_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic: start detection, mid-bit sampling and frame completion.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + 16'd1;
    idx_s   = idx_r;
    char_s  = char_r;
    par_s   = par_r;
    data_s  = data_r;
    valid_s = 1'b0;
    perr_s  = perr_r;
    ferr_s  = ferr_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        cnt_s = 16'd0;
        // A start needs a prior high, so a held-low line cannot retrigger.
        if (rs_prev_r && !rs_r) begin
          state_s = START;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = 16'd0;
          if (!rs_r) begin
            state_s = DATA;
            idx_s   = 3'd0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_s = IDLE;
            busy_s  = 1'b0;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_M1) begin
          cnt_s  = 16'd0;
          char_s = {rs_r, char_r[6:1]};
          if (idx_r == 3'd6) begin
            state_s = PARITY;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (cnt_r == BIT_M1) begin
          cnt_s   = 16'd0;
          par_s   = rs_r;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (cnt_r == BIT_M1) begin
          cnt_s   = 16'd0;
          state_s = IDLE;
          valid_s = 1'b1;
          data_s  = char_r;
          perr_s  = (par_r != even_parity(char_r));
          ferr_s  = !rs_r;
          busy_s  = 1'b0;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 16'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign data       = data_r;
  assign valid      = valid_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, parity error, break, glitch,
// back-to-back frames and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [6:0] data;
  logic       valid, parity_err, frame_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  logic [6:0] data_q[$];
  logic       perr_q[$];
  logic       ferr_q[$];
  int         cyc_q[$];

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid pulse with its outputs and cycle number.
  always @(negedge clk) begin
    if (valid) begin
      data_q.push_back(data);
      perr_q.push_back(parity_err);
      ferr_q.push_back(frame_err);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one 10-bit frame, each bit held for CPB clocks.
  task automatic send_frame(input logic [6:0] ch, input logic par, input logic stp);
    logic [9:0] bits;
    bits = {stp, par, ch, 1'b0};
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // Pop one captured frame and compare it with the expected contents.
  task automatic take_frame(input string tag, input logic [6:0] ch, input logic pe, input logic fe);
    if (data_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_data"}, {25'd0, data_q.pop_front()}, {25'd0, ch});
      check({tag, "_perr"}, {31'd0, perr_q.pop_front()}, {31'd0, pe});
      check({tag, "_ferr"}, {31'd0, ferr_q.pop_front()}, {31'd0, fe});
      void'(cyc_q.pop_front());
    end
  endtask

  initial begin
    int lat;
    logic [9:0] bits;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_data",  {25'd0, data}, 32'd0);
    check("rst_perr",  {31'd0, parity_err}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // 'A', correct parity and stop: also check latency
    send_frame(7'h41, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    check("a_count", data_q.size(), 32'd1);
    if (cyc_q.size() > 0) begin
      lat = cyc_q[0] - start_cyc;
      check("a_latency_ok", {31'd0, (lat >= 4121 && lat <= 4129)}, 32'd1);
    end
    take_frame("a", 7'h41, 1'b0, 1'b0);
    check("a_busy_after", {31'd0, busy}, 32'd0);

    // 7'h37 has odd weight, parity bit forced to 0
    send_frame(7'h37, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    check("p_count", data_q.size(), 32'd1);
    take_frame("p", 7'h37, 1'b1, 1'b0);

    // 7'h55 with a low stop bit, then a held-low break
    send_frame(7'h55, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check("brk_count", data_q.size(), 32'd1);
    take_frame("brk", 7'h55, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    check("brk_no_more", data_q.size(), 32'd0);
    check("brk_ferr_hold", {31'd0, frame_err}, 32'd1);

    // Short low glitch: no frame, busy drops again
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("gl_busy_mid", {31'd0, busy}, 32'd1);
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("gl_busy_low", {31'd0, busy}, 32'd0);
    check("gl_no_valid", data_q.size(), 32'd0);
    send_frame(7'h5A, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    take_frame("gl_next", 7'h5A, 1'b0, 1'b0);

    // Back-to-back frames
    send_frame(7'h00, 1'b0, 1'b1);
    send_frame(7'h7F, 1'b1, 1'b1);
    send_frame(7'h2A, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    check("b2b_count", data_q.size(), 32'd3);
    take_frame("b2b0", 7'h00, 1'b0, 1'b0);
    take_frame("b2b1", 7'h7F, 1'b0, 1'b0);
    take_frame("b2b2", 7'h2A, 1'b0, 1'b0);

    // Reset during data bit 3 of 7'h33, then a clean 7'h12
    bits = {1'b1, 1'b0, 7'h33, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = bits[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rr_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    rst = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    check("rr_no_valid", data_q.size(), 32'd0);
    send_frame(7'h12, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    check("rr_count", data_q.size(), 32'd1);
    take_frame("rr", 7'h12, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 434, giving clocks per bit period (50 MHz / 115200 baud).
REQ-002 The block SHALL have the derived constant HALF = CLK_PER_BIT/2 (integer division, 217 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port data, output, 7 bits: last received ASCII character.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-008 The block SHALL have port parity_err, output, 1 bit: even-parity mismatch flag for the current frame.
REQ-009 The block SHALL have port frame_err, output, 1 bit: stop bit sampled low for the current frame.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is being received.

Function
REQ-011 The frame format SHALL be: start bit (0), data[0..6] LSB first, even parity bit (^data), stop bit (1); 10 bits total.
REQ-012 rx SHALL pass through a two-flop synchronizer, initialised to 1; all decisions SHALL use the synchronized value rs and its one-cycle-delayed copy.
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP, with one clock counter (at least 16 bits) and one 3-bit bit index.
REQ-014 In IDLE, a falling edge on rs (previous 1, current 0) SHALL move the block to START with the counter cleared and busy set; call that cycle D.
REQ-015 In START at counter == HALF-1 (cycle D+216), rs == 0 SHALL move the block to DATA; rs == 1 SHALL be a false start: return to IDLE, busy low, no valid pulse.
REQ-016 Bit k (k=1..9: data0..data6, parity, stop) SHALL be sampled at cycle D+216+k*CLK_PER_BIT; the counter SHALL reset to 0 at each sample.
REQ-017 In DATA, samples SHALL be shifted into the internal character LSB first; after the 7th sample the block SHALL move to PARITY.
REQ-018 In PARITY, the sampled bit SHALL be stored; the block SHALL then move to STOP.
REQ-019 At the STOP sample, in the cycle that follows (D+4123): valid=1 for exactly one cycle; data = character; parity_err = (parity sample != ^character); frame_err = !stop sample; busy=0; state = IDLE.
REQ-020 valid SHALL pulse even when parity_err or frame_err is set; data SHALL always be updated with the received bits.
REQ-021 data, parity_err and frame_err SHALL hold their values until the next valid pulse.
REQ-022 The block SHALL return from a frame_err frame to IDLE and SHALL NOT accept a new start until rs has been seen high, because falling-edge detection requires a prior 1; a held-low line (break) SHALL therefore yield exactly one frame.
REQ-023 A frame beginning immediately after a stop bit SHALL be received back-to-back with no lost frame.
REQ-024 Glitches on rx shorter than HALF cycles that start a frame SHALL be rejected by REQ-015.

Reset
REQ-025 While rst=1: state IDLE, counters 0, synchronizer flops 1, data=0, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-026 Asserting rst mid-frame SHALL abandon the frame with no valid pulse; after release the block SHALL wait for a new falling edge.

Verification
REQ-027 Serialize 'A' (7'h41, parity 0, stop 1) at 434 clk/bit -> one valid pulse at D+4123 (±2 clks for synchronizer), data=7'h41, parity_err=0, frame_err=0.
REQ-028 Serialize 7'h37 with parity bit forced to 0 -> valid pulses, data=7'h37, parity_err=1, frame_err=0.
REQ-029 Serialize 7'h55 with stop bit 0, then hold rx low for 20 bit periods -> exactly one valid pulse with frame_err=1; no further valid until rx returns high and a new start is sent.
REQ-030 Drive rx low for 100 clks, then high -> no valid pulse; busy returns low by about D+217; the next good frame is received correctly.
REQ-031 Send three back-to-back frames 7'h00, 7'h7F, 7'h2A -> three valid pulses with matching data and no errors.
REQ-032 Assert rst during data bit 3 of a frame, release it, then send 7'h12 -> no valid pulse for the aborted frame; one valid pulse with data=7'h12.
